// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
// Shared types for the two-master memory arbiter: FSM states, request bundle, round-robin pick.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // rdata handed back when the slave never answers
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // One master request as forwarded to the slave
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // Round-robin choice between two masters. Returns the index to grant;
  // only meaningful when at least one valid is high.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end
    return v1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-master / one-slave round-robin arbiter for the single-port program/data memory bus.
// Latency: master valid at t -> s_valid at t+1 -> master ready one cycle after s_ready (min 3 cycles).
// Backpressure: loser's request is held pending by its master; grant held until ready, timeout or abort.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   m0_* / m1_*                       master buses (valid, addr, wdata, wstrb in; ready, rdata out)
//   s_*                               slave bus (valid, addr, wdata, wstrb out; ready, rdata in)
//   timeout_err                       one-cycle pulse when the watchdog ends a transaction
//   grant_id                          index of the current / most recently granted master
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output logic        grant_id
);

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  bus_req_t    s_req_q, s_req_d;
  logic        s_valid_q, s_valid_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] cnt_q, cnt_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        timeout_err_q, timeout_err_d;

  bus_req_t    m0_req, m1_req;
  logic        pick;
  logic        gnt_vld;
  logic        resp_vld;
  logic [31:0] resp_dat;

  assign m0_req  = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req  = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign pick    = rr_pick(m0_valid, m1_valid, last_grant_q);
  assign gnt_vld = grant_q ? m1_valid : m0_valid;

  always_comb begin
    state_d       = state_q;
    s_req_d       = s_req_q;
    s_valid_d     = s_valid_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = '0;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    timeout_err_d = 1'b0;
    resp_vld      = 1'b0;
    resp_dat      = s_rdata;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d   = pick;
          s_req_d   = pick ? m1_req : m0_req;
          s_valid_d = 1'b1;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        // s_ready outranks an expiring watchdog in the same cycle
        if (s_ready) begin
          resp_vld = 1'b1;
          resp_dat = s_rdata;
        end else if (WD_EN && (cnt_q == WD_LAST)) begin
          resp_vld      = 1'b1;
          resp_dat      = ERR_DATA;
          timeout_err_d = 1'b1;
        end else if (!gnt_vld) begin
          // master withdrew: drop the slave request silently, keep round-robin history
          s_valid_d = 1'b0;
          state_d   = IDLE;
          cnt_d     = '0;
        end

        if (resp_vld) begin
          s_valid_d    = 1'b0;
          last_grant_d = grant_q;
          state_d      = RESP;
          cnt_d        = '0;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = resp_dat;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = resp_dat;
          end
        end
      end

      RESP: begin
        // ready is high during this cycle only; slave is not sampled here
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      s_req_q       <= '0;
      s_valid_q     <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_req_q       <= s_req_d;
      s_valid_q     <= s_valid_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign s_valid     = s_valid_q;
  assign s_addr      = s_req_q.addr;
  assign s_wdata     = s_req_q.wdata;
  assign s_wstrb     = s_req_q.wstrb;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign timeout_err = timeout_err_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: transaction-level model plus directed scenarios.
// Latency: model predicts outputs per clock from the request/response rules.
// Backpressure: masters hold valid until their ready; slave latency set per scenario.
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, s_valid, timeout_err, grant_id;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .grant_id(grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: answers slave_lat cycles into a request (<=0 means never)
  int          scnt = 0;
  int          slave_lat = 1;
  logic [31:0] slave_data = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      s_ready = 1'b0;
      scnt = 0;
    end else if (s_ready) begin
      s_ready = 1'b0;
      scnt = 0;
    end else if (!s_valid) begin
      scnt = 0;
    end else begin
      scnt++;
      if (slave_lat > 0 && scnt == slave_lat) begin
        s_ready = 1'b1;
        s_rdata = slave_data;
      end
    end
  end

  // Transaction model: owner = master being served (-1 none), busy_cyc = cycles spent waiting
  logic        exp_s_valid, exp_tmo, exp_gid, exp_rdy0, exp_rdy1;
  logic [31:0] exp_s_addr, exp_s_wdata, exp_rdata0, exp_rdata1;
  logic [3:0]  exp_s_wstrb;
  int          owner, busy_cyc, last;
  bit          resp_now;

  task automatic model_deliver(input logic [31:0] d, input logic t);
    if (owner == 1) begin exp_rdy1 = 1'b1; exp_rdata1 = d; end
    else begin exp_rdy0 = 1'b1; exp_rdata0 = d; end
    exp_tmo = t; exp_s_valid = 1'b0; last = owner; owner = -1; resp_now = 1'b1;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_s_valid = 0; exp_tmo = 0; exp_gid = 0; exp_rdy0 = 0; exp_rdy1 = 0;
      exp_s_addr = 0; exp_s_wdata = 0; exp_s_wstrb = 0; exp_rdata0 = 0; exp_rdata1 = 0;
      owner = -1; busy_cyc = 0; last = 1; resp_now = 0;
    end else if (resp_now) begin
      resp_now = 0; exp_rdy0 = 0; exp_rdy1 = 0; exp_tmo = 0;
    end else if (owner < 0) begin
      if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) owner = 1 - last;
        else owner = m1_valid ? 1 : 0;
        exp_gid = (owner == 1); exp_s_valid = 1; busy_cyc = 0;
        exp_s_addr  = (owner == 1) ? m1_addr  : m0_addr;
        exp_s_wdata = (owner == 1) ? m1_wdata : m0_wdata;
        exp_s_wstrb = (owner == 1) ? m1_wstrb : m0_wstrb;
      end
    end else begin
      busy_cyc++;
      if (s_ready) model_deliver(s_rdata, 1'b0);
      else if (TMO != 0 && busy_cyc == TMO) model_deliver(32'hDEAD_BEEF, 1'b1);
      else if (!((owner == 1) ? m1_valid : m0_valid)) begin
        exp_s_valid = 0; owner = -1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (resetn) begin
      chk("s_valid", s_valid, exp_s_valid);
      chk("m0_ready", m0_ready, exp_rdy0);
      chk("m1_ready", m1_ready, exp_rdy1);
      chk("m0_rdata", m0_rdata, exp_rdata0);
      chk("m1_rdata", m1_rdata, exp_rdata1);
      chk("timeout_err", timeout_err, exp_tmo);
      chk("grant_id", grant_id, exp_gid);
      if (exp_s_valid) begin
        chk("s_addr", s_addr, exp_s_addr);
        chk("s_wdata", s_wdata, exp_s_wdata);
        chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, exp_s_wstrb});
      end
    end
  end

  // Observers for literal checks: m1 payload seen on the slave, and stability while s_valid
  logic [31:0] seen_m1_wdata = '0, prev_addr = '0, prev_wdata = '0;
  logic [3:0]  seen_m1_wstrb = '0, prev_wstrb = '0;
  logic        prev_sv = 1'b0;
  int          held_bad = 0;
  always @(negedge clk) begin
    if (s_valid && grant_id) begin seen_m1_wdata = s_wdata; seen_m1_wstrb = s_wstrb; end
    if (s_valid && prev_sv && {s_addr, s_wdata, s_wstrb} != {prev_addr, prev_wdata, prev_wstrb})
      held_bad++;
    prev_sv = s_valid; prev_addr = s_addr; prev_wdata = s_wdata; prev_wstrb = s_wstrb;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin m0_valid = 1; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
    else begin m1_valid = 1; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
  endtask

  task automatic drop(input int m);
    if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
  endtask

  // Advance until a master sees ready; that master then withdraws its valid
  task automatic wait_resp(input int budget, output int who, output int sv_cyc, output int tmo_cnt);
    who = -1; sv_cyc = 0; tmo_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_valid) sv_cyc++;
      if (timeout_err) tmo_cnt++;
      if (m0_ready || m1_ready) begin
        who = m1_ready ? 1 : 0;
        drop(who);
        break;
      end
    end
    chk("resp_within_budget", {31'd0, who >= 0}, 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int who, sv, tc, rdy_cnt;
    do_reset();
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);

    // 1: m0 read, slave answers in the second BUSY cycle
    slave_lat = 2; slave_data = 32'h1234_5678;
    set_req(0, 32'h0000_0010, 32'h0, 4'b0000);
    tick();
    chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
    chk("t1_s_addr", s_addr, 32'h10);
    chk("t1_s_wstrb", {28'd0, s_wstrb}, 32'd0);
    wait_resp(10, who, sv, tc);
    chk("t1_who", who, 0);
    chk("t1_s_valid_cycles", sv + 1, 2);
    chk("t1_rdata", m0_rdata, 32'h1234_5678);
    tick();

    // 2: simultaneous requests alternate, m0 first after reset
    do_reset();
    slave_lat = 1;
    for (int r = 0; r < 4; r++) begin
      slave_data = 32'h1000 + r;
      set_req(0, 32'h100 + r, 32'h0, 4'b0000);
      set_req(1, 32'h200 + r, 32'h5A5A_0000 + r, 4'b1111);
      wait_resp(10, who, sv, tc);
      chk("t2_first", who, 0);
      slave_data = 32'h2000 + r;
      wait_resp(10, who, sv, tc);
      chk("t2_second", who, 1);
      chk("t2_m1_wdata", seen_m1_wdata, 32'h5A5A_0000 + r);
      chk("t2_m1_wstrb", {28'd0, seen_m1_wstrb}, 32'hF);
      chk("t2_m0_rdata", m0_rdata, 32'h1000 + r);
      chk("t2_m1_rdata", m1_rdata, 32'h2000 + r);
      tick();
    end

    // 3: m1 byte write, held stable until s_ready
    slave_lat = 3; slave_data = 32'h0;
    held_bad = 0;
    set_req(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001);
    wait_resp(10, who, sv, tc);
    chk("t3_who", who, 1);
    chk("t3_s_valid_cycles", sv, 3);
    chk("t3_wdata", seen_m1_wdata, 32'h0000_00A5);
    chk("t3_wstrb", {28'd0, seen_m1_wstrb}, 32'h1);
    chk("t3_held", held_bad, 0);
    tick();

    // 4: slave never answers -> watchdog, then normal service
    slave_lat = -1;
    set_req(0, 32'h20, 32'h0, 4'b0000);
    wait_resp(20, who, sv, tc);
    chk("t4_who", who, 0);
    chk("t4_busy_cycles", sv, TMO);
    chk("t4_tmo_pulses", tc, 1);
    chk("t4_rdata", m0_rdata, 32'hDEAD_BEEF);
    tick();
    chk("t4_tmo_cleared", {31'd0, timeout_err}, 32'd0);
    slave_lat = 1; slave_data = 32'hCAFE_0001;
    set_req(1, 32'h30, 32'h0, 4'b0000);
    wait_resp(10, who, sv, tc);
    chk("t4_next_who", who, 1);
    chk("t4_next_tmo", tc, 0);
    chk("t4_next_rdata", m1_rdata, 32'hCAFE_0001);
    tick();

    // 5: m1 aborts in its 3rd BUSY cycle, pending m0 served next
    slave_lat = -1;
    set_req(1, 32'h40, 32'h0, 4'b0000);
    tick();
    chk("t5_grant_m1", {31'd0, grant_id}, 32'd1);
    set_req(0, 32'h50, 32'h0, 4'b0000);
    tick();
    tick();
    drop(1);
    tick();
    chk("t5_s_valid_fell", {31'd0, s_valid}, 32'd0);
    chk("t5_no_m1_ready", {31'd0, m1_ready}, 32'd0);
    slave_lat = 2; slave_data = 32'h0000_0055;
    tick();
    chk("t5_grant_m0", {31'd0, grant_id}, 32'd0);
    chk("t5_s_addr", s_addr, 32'h50);
    wait_resp(10, who, sv, tc);
    chk("t5_who", who, 0);
    chk("t5_rdata", m0_rdata, 32'h0000_0055);
    tick();

    // 6: asynchronous reset mid-BUSY
    slave_lat = -1;
    set_req(0, 32'h60, 32'h0, 4'b0000);
    tick();
    tick();
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t6_s_valid", {31'd0, s_valid}, 32'd0);
    chk("t6_s_addr", s_addr, 32'd0);
    chk("t6_s_wstrb", {28'd0, s_wstrb}, 32'd0);
    chk("t6_m0_rdata", m0_rdata, 32'd0);
    chk("t6_m1_rdata", m1_rdata, 32'd0);
    chk("t6_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
    chk("t6_tmo", {31'd0, timeout_err}, 32'd0);
    chk("t6_grant_id", {31'd0, grant_id}, 32'd0);
    m0_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m0_ready || m1_ready) rdy_cnt++;
    end
    chk("t6_no_ready_after_release", rdy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
